// File: rtl/uart_rx_sipo.sv
// Oversampled UART receiver: synchronizes the serial line, frames start/data/parity/stop
// bits with a mid-bit sampling tick counter, and presents the byte plus error flags.
module uart_rx_sipo #(
    parameter int OVS = 16
) (
    input  logic       baud_out,
    input  logic       rst,
    input  logic       data_in,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       stop_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [4:0] TICK_MID = 5'(OVS / 2 - 1);
    localparam logic [4:0] TICK_END = 5'(OVS - 1);

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic        rxs;
    logic [4:0]  tick_q, tick_d;
    logic [2:0]  bit_q, bit_d;
    logic        stop2_q, stop2_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  par_cfg_q, par_cfg_d;
    logic        stop_cfg_q, stop_cfg_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        rx_active_q, rx_active_d;
    logic        rx_done_q, rx_done_d;
    logic        parity_error_q, parity_error_d;
    logic        stop_error_q, stop_error_d;
    logic        par_en;
    logic        par_exp;
    logic        tick_end;

    assign rxs      = sync_q[1];
    assign par_en   = (par_cfg_q == 2'b01) || (par_cfg_q == 2'b10);
    // Even parity expects the XOR of the data; odd parity expects its complement.
    assign par_exp  = (par_cfg_q == 2'b10) ? (^shift_q) : ~(^shift_q);
    assign tick_end = (tick_q == TICK_END);

    always_ff @(posedge baud_out) begin
        if (!rst) begin
            state_q        <= IDLE;
            sync_q         <= 2'b11;
            tick_q         <= 5'd0;
            bit_q          <= 3'd0;
            stop2_q        <= 1'b0;
            shift_q        <= 8'h00;
            par_cfg_q      <= 2'b00;
            stop_cfg_q     <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            data_out_q     <= 8'h00;
            rx_active_q    <= 1'b0;
            rx_done_q      <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= {sync_q[0], data_in};
            tick_q         <= tick_d;
            bit_q          <= bit_d;
            stop2_q        <= stop2_d;
            shift_q        <= shift_d;
            par_cfg_q      <= par_cfg_d;
            stop_cfg_q     <= stop_cfg_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            data_out_q     <= data_out_d;
            rx_active_q    <= rx_active_d;
            rx_done_q      <= rx_done_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        tick_d         = tick_end ? 5'd0 : tick_q + 5'd1;
        bit_d          = bit_q;
        stop2_d        = stop2_q;
        shift_d        = shift_q;
        par_cfg_d      = par_cfg_q;
        stop_cfg_d     = stop_cfg_q;
        perr_d         = perr_q;
        ferr_d         = ferr_q;
        data_out_d     = data_out_q;
        rx_active_d    = rx_active_q;
        rx_done_d      = 1'b0;
        parity_error_d = parity_error_q;
        stop_error_d   = stop_error_q;

        case (state_q)
            IDLE: begin
                tick_d = 5'd0;
                bit_d  = 3'd0;
                if (!rxs) begin
                    state_d     = START;
                    rx_active_d = 1'b1;
                end
            end

            START: begin
                if (tick_q == TICK_MID) begin
                    tick_d = 5'd0;
                    if (!rxs) begin
                        // Frame configuration is frozen here so mid-frame input changes are ignored.
                        state_d    = DATA;
                        par_cfg_d  = parity_type;
                        stop_cfg_d = stop_bits;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        bit_d      = 3'd0;
                        stop2_d    = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        rx_active_d = 1'b0;
                    end
                end
            end

            DATA: begin
                if (tick_end) begin
                    shift_d[bit_q] = rxs;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = par_en ? PARITY : STOP;
                    end
                end
            end

            PARITY: begin
                if (tick_end) begin
                    if (rxs != par_exp) begin
                        perr_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end

            STOP: begin
                if (tick_end) begin
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end
                    if (stop_cfg_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        // Last stop sample: publish the frame; the flag includes this sample.
                        state_d        = IDLE;
                        rx_done_d      = 1'b1;
                        rx_active_d    = 1'b0;
                        data_out_d     = shift_q;
                        parity_error_d = perr_q;
                        stop_error_d   = ferr_q | ~rxs;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                rx_active_d = 1'b0;
            end
        endcase
    end

    assign data_out     = data_out_q;
    assign rx_active    = rx_active_q;
    assign rx_done      = rx_done_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;

endmodule

// File: doc/uart_rx_sipo.md
UART_RX_SIPO -- requirements
Module: uart_rx_sipo

Interface
REQ-001 Parameter OVS, 16, baud_out ticks per serial bit; legal values are even integers from 8 to 32.
REQ-002 baud_out  input  1  sole clock, OVS x bit rate, rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 data_in  input  1  serial line from transmitter; idles high.
REQ-005 parity_type  input  2  00/11 no parity, 01 odd, 10 even.
REQ-006 stop_bits  input  1  0 selects one stop bit, 1 selects two.
REQ-007 data_out  output  8  last received data byte.
REQ-008 rx_active  output  1  high while a frame is being received.
REQ-009 rx_done  output  1  one-cycle pulse when a frame completes.
REQ-010 parity_error  output  1  parity mismatch in the last frame.
REQ-011 stop_error  output  1  framing error (a stop bit sampled low) in the last frame.

Function
REQ-012 data_in SHALL pass through a 2-flop synchronizer; both flops reset to 1; all sampling below uses the synchronizer output (rxs).
REQ-013 Frame order SHALL be: start (0), D0..D7 (LSB first), parity bit (if enabled), then 1 or 2 stop bits (1); the frame is 10 to 12 bits long.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-015 Tick counter SHALL be 5 bits wide, be cleared on every state entry, and wrap at OVS-1.
REQ-016 IDLE: when rxs=0, go to START with the tick counter at 0; rx_active goes high in the same cycle.
REQ-017 START: at tick OVS/2-1 (mid-bit), if rxs=0, go to DATA with the counter cleared, and latch parity_type and stop_bits into internal config registers.
REQ-018 START, false start: if rxs=1 at tick OVS/2-1, return to IDLE with no rx_done and no change to any error flag.
REQ-019 DATA: sample rxs at tick OVS-1 (one full bit after the start midpoint) into shift register bit index = bit counter; after 8 bits, go to PARITY if parity is enabled, otherwise go to STOP.
REQ-020 PARITY: sample at tick OVS-1 and compute the expected bit (even: ^D; odd: ~^D); a mismatch sets an internal parity flag.
REQ-021 STOP: sample at tick OVS-1; any stop sample equal to 0 sets an internal framing flag; with latched stop_bits=1, a second stop bit is sampled.
REQ-022 On the last stop sample, the next cycle SHALL: pulse rx_done for one cycle; update data_out, parity_error and stop_error together; drop rx_active; enter IDLE.
REQ-023 data_out and both error outputs SHALL hold their values until the next rx_done; an aborted false start leaves them unchanged.
REQ-024 parity_error SHALL be 0 for any frame with parity disabled.
REQ-025 When a frame had a stop error, data_out is still updated.
REQ-026 After a stop error, IDLE re-arms immediately; a line held low (break) produces back-to-back frames, each with stop_error=1.
REQ-027 Changes to parity_type or stop_bits during a frame SHALL affect only the next frame.
REQ-028 Latency from the start falling edge on data_in to rx_done SHALL be 2 (synchronizer) + OVS/2 + (frame_bits-1)*OVS + 1 cycles, +/-1 for edge phase.

Reset
REQ-029 With rst=0 at a clock edge, the block SHALL set: FSM to IDLE, counters to 0, synchronizer to 1, data_out=8'h00, rx_active=0, rx_done=0, parity_error=0, stop_error=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no rx_done pulse; reception resumes on the first start bit after rst returns to 1.

Verification
REQ-031 OVS=16, no parity, 1 stop, send 8'hA5 -> one rx_done pulse, data_out=8'hA5, both error flags 0, rx_active high for about 160 cycles.
REQ-032 Even parity, 2 stop bits, 8'h03 sent with parity bit 1 -> parity_error=1; the same byte with parity bit 0 -> parity_error=0.
REQ-033 Odd parity, 8'hFF with stop bit forced to 0 -> rx_done pulses, data_out=8'hFF, stop_error=1; the next clean frame 8'h12 clears stop_error to 0.
REQ-034 Low glitch of 4 cycles on an idle line -> returns to IDLE, no rx_done, outputs unchanged.
REQ-035 rst driven low for 1 cycle during D3 of a frame -> all outputs at reset values, no rx_done; the following frame 8'h5A is received correctly.
REQ-036 Two frames back-to-back with zero idle time (8'h00 then 8'hC3) -> two rx_done pulses, data_out=8'h00 then 8'hC3.
